// File: rtl/mem_stage_pkg.sv
// Shared widths, funct3 access codes and FSM state encoding for the MEM stage.
package mem_stage_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Bytes moved per access; any width code other than byte/half is a word.
    function automatic logic [2:0] op_bytes(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// MEM-stage bus: EX/MEM inputs, byte-wide RAM port, arbiter handshake and MEM/WB outputs.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_rd_enable;
    logic [DATA_W-1:0]     in_vd;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic [2:0]            in_mem_op;
    logic [DATA_W-1:0]     in_store_data;
    logic                  mem_grant;
    logic [7:0]            ram_din;
    logic [ADDR_W-1:0]     ram_a;
    logic [7:0]            ram_dout;
    logic                  ram_wr;
    logic                  mem_req;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_rd_enable;
    logic [DATA_W-1:0]     out_vd;
    logic                  stall_req;

    modport slave (
        input  in_rd, in_rd_enable, in_vd, in_mem_read, in_mem_write, in_mem_op,
               in_store_data, mem_grant, ram_din,
        output ram_a, ram_dout, ram_wr, mem_req, out_rd, out_rd_enable, out_vd, stall_req
    );

    modport master (
        output in_rd, in_rd_enable, in_vd, in_mem_read, in_mem_write, in_mem_op,
               in_store_data, mem_grant, ram_din,
        input  ram_a, ram_dout, ram_wr, mem_req, out_rd, out_rd_enable, out_vd, stall_req
    );

endinterface

// File: rtl/mem_ext.sv
// Load-result assembly: picks the loaded bytes and sign/zero-extends them per funct3.
module mem_ext
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_buf,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        case (i_op)
            F3_B:    o_result = {{(DATA_W-8){i_buf[7]}}, i_buf[7:0]};
            F3_BU:   o_result = {{(DATA_W-8){1'b0}}, i_buf[7:0]};
            F3_H:    o_result = {{(DATA_W-16){i_buf[15]}}, i_buf[15:0]};
            F3_HU:   o_result = {{(DATA_W-16){1'b0}}, i_buf[15:0]};
            F3_W:    o_result = i_buf;
            default: o_result = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: passes ALU results through and runs loads/stores byte-serially
// over the arbitrated RAM port, stalling the front of the pipe until done.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    mem_stage_if.slave  bus
);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_k, w_k_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_op;
    logic              r_is_load;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_buf;
    logic [7:0]        r_din_save;
    logic              r_rdy_d;

    logic              w_mem_op;
    logic              w_launch;
    logic              w_capture;
    logic [2:0]        w_n;
    logic [1:0]        w_buf_idx;
    logic [7:0]        w_din;
    logic [7:0]        w_store_byte;
    logic [DATA_W-1:0] w_load_result;

    assign w_mem_op     = bus.in_mem_read | bus.in_mem_write;
    assign w_n          = op_bytes(r_op);
    assign w_buf_idx    = r_k[1:0] - 2'd1;
    assign w_store_byte = r_store_data[{r_k[1:0], 3'b000} +: 8];
    // RAM data is only valid the cycle after its address; after a freeze the
    // byte for the previous address was parked in r_din_save.
    assign w_din        = r_rdy_d ? bus.ram_din : r_din_save;

    mem_ext u_ext (
        .i_buf    (r_buf),
        .i_op     (r_op),
        .o_result (w_load_result)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && bus.mem_grant) begin
                    w_state_nxt = S_ACCESS;
                    w_k_nxt     = 3'd0;
                    w_launch    = 1'b1;
                end
            end
            S_ACCESS: begin
                w_k_nxt = r_k + 3'd1;
                if (r_is_load) begin
                    w_capture = (r_k != 3'd0);
                    if (r_k == w_n) w_state_nxt = S_DONE;
                end else if (r_k == w_n - 3'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 3'd0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= 3'd0;
            r_buf        <= '0;
            r_addr       <= '0;
            r_op         <= 3'd0;
            r_is_load    <= 1'b0;
            r_store_data <= '0;
            r_din_save   <= 8'd0;
            r_rdy_d      <= 1'b1;
        end else begin
            r_rdy_d <= rdy;
            if (!rdy && r_rdy_d) r_din_save <= bus.ram_din;
            if (rdy) begin
                r_state <= w_state_nxt;
                r_k     <= w_k_nxt;
                if (w_launch) begin
                    r_addr       <= bus.in_vd;
                    r_op         <= bus.in_mem_op;
                    r_is_load    <= bus.in_mem_read;
                    r_store_data <= bus.in_store_data;
                end
                if (w_capture) r_buf[{w_buf_idx, 3'b000} +: 8] <= w_din;
            end
        end
    end

    always_comb begin
        bus.ram_a         = '0;
        bus.ram_dout      = 8'd0;
        bus.ram_wr        = 1'b0;
        bus.mem_req       = 1'b0;
        bus.stall_req     = 1'b0;
        bus.out_rd        = bus.in_rd;
        bus.out_rd_enable = bus.in_rd_enable;
        bus.out_vd        = bus.in_vd;
        if (rst) begin
            bus.out_rd        = '0;
            bus.out_rd_enable = 1'b0;
            bus.out_vd        = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        bus.stall_req     = 1'b1;
                        bus.mem_req       = 1'b1;
                        bus.out_rd_enable = 1'b0;
                    end
                end
                S_ACCESS: begin
                    bus.stall_req     = 1'b1;
                    bus.mem_req       = 1'b1;
                    bus.out_rd_enable = 1'b0;
                    bus.ram_a         = r_addr + ADDR_W'(r_k);
                    bus.ram_wr        = !r_is_load && rdy;
                    bus.ram_dout      = r_is_load ? 8'd0 : w_store_byte;
                end
                S_DONE: begin
                    if (r_is_load) bus.out_vd = w_load_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random loads/stores
// compared against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_stage_if bus();

    mem_stage u_dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] a_log   [$];

    logic [31:0] vd;
    logic [4:0]  rd_o;
    logic        rd_en_o;
    int          stalls;
    int          wrs;
    logic        done;

    logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_ops [3] = '{3'b000, 3'b001, 3'b010};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    // RAM with one-cycle read latency, free-running regardless of rdy.
    always @(posedge clk) begin
        bus.ram_din <= ram_rd(bus.ram_a);
        if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
    end

    function automatic int n_bytes(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
        logic [31:0] raw;
        raw = 32'd0;
        for (int i = 0; i < n_bytes(op); i++)
            raw = raw + (32'(ref_rd(addr + 32'(i))) << (8 * i));
        if (op == 3'b000 && raw >= 32'd128)   return raw - 32'd256;
        if (op == 3'b001 && raw >= 32'd32768) return raw - 32'd65536;
        return raw;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] sdata);
        for (int i = 0; i < n_bytes(op); i++)
            ref_mem[addr + 32'(i)] = 8'((sdata >> (8 * i)) & 32'hFF);
    endtask

    // Presents one memory op and runs it to its DONE cycle; pause_at < 0 means no rdy freeze.
    task automatic run_op(input logic rd_f, input logic wr_f, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rd_en,
                          input int grant_delay, input int pause_at);
        bus.in_mem_read   = rd_f;
        bus.in_mem_write  = wr_f;
        bus.in_mem_op     = op;
        bus.in_vd         = addr;
        bus.in_store_data = sdata;
        bus.in_rd         = rd;
        bus.in_rd_enable  = rd_en;
        stalls = 0; wrs = 0; done = 1'b0; vd = '0; rd_o = '0; rd_en_o = 1'b0;
        a_log.delete();
        for (int i = 0; i < 64 && !done; i++) begin
            bus.mem_grant = (i >= grant_delay);
            rdy = !(pause_at >= 0 && i >= pause_at && i < pause_at + 3);
            #1;
            a_log.push_back(bus.ram_a);
            if (bus.ram_wr) wrs++;
            if (bus.stall_req) stalls++;
            else if (stalls > 0) begin
                vd = bus.out_vd; rd_o = bus.out_rd; rd_en_o = bus.out_rd_enable;
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_mem_read  = 1'b0;
        bus.in_mem_write = 1'b0;
        bus.mem_grant    = 1'b0;
        rdy              = 1'b1;
    endtask

    task automatic do_op(input string tag, input logic rd_f, input logic wr_f, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rd_en, input int gd, input int pause_at);
        logic [31:0] exp_vd;
        int n, exp_stalls, exp_wrs;
        n          = n_bytes(op);
        exp_vd     = rd_f ? ref_load(addr, op) : addr;
        exp_stalls = n + (rd_f ? 2 : 1) + gd + (pause_at >= 0 ? 3 : 0);
        exp_wrs    = rd_f ? 0 : n;
        if (!rd_f) ref_store(addr, op, sdata);
        run_op(rd_f, wr_f, op, addr, sdata, rd, rd_en, gd, pause_at);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".vd"}, vd, exp_vd);
        check({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, ".wr_cycles"}, 32'(wrs), 32'(exp_wrs));
        check({tag, ".rd"}, 32'(rd_o), 32'(rd));
        check({tag, ".rd_en"}, 32'(rd_en_o), 32'(rd_en));
        if (!rd_f)
            for (int i = 0; i <= n; i++)
                check($sformatf("%s.mem%0d", tag, i), 32'(ram_rd(addr + 32'(i))), 32'(ref_rd(addr + 32'(i))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ld, wr_f, rd_en;
        logic [2:0]  op;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        int          gd, pause_at;

        // Reset with a pending load on the inputs: every output must read zero.
        rst = 1'b1; rdy = 1'b1;
        bus.in_rd = 5'd7; bus.in_rd_enable = 1'b1; bus.in_vd = 32'h1234_5678;
        bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0; bus.in_mem_op = 3'b010;
        bus.in_store_data = 32'hFFFF_FFFF; bus.mem_grant = 1'b1;
        @(negedge clk); #1;
        check("rst.out_vd", bus.out_vd, 32'd0);
        check("rst.out_rd", 32'(bus.out_rd), 32'd0);
        check("rst.out_rd_en", 32'(bus.out_rd_enable), 32'd0);
        check("rst.stall", 32'(bus.stall_req), 32'd0);
        check("rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst.ram_wr", 32'(bus.ram_wr), 32'd0);
        @(negedge clk);

        // Non-memory op passes straight through in the same cycle.
        rst = 1'b0; bus.in_mem_read = 1'b0; bus.mem_grant = 1'b0;
        bus.in_vd = 32'hDEAD_BEEF; bus.in_rd = 5'd5; bus.in_rd_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("add.out_vd", bus.out_vd, 32'hDEAD_BEEF);
            check("add.out_rd", 32'(bus.out_rd), 32'd5);
            check("add.stall", 32'(bus.stall_req), 32'd0);
            check("add.mem_req", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
        end

        // LW at 0x1000.
        preload(32'h1000, 8'h78); preload(32'h1001, 8'h56);
        preload(32'h1002, 8'h34); preload(32'h1003, 8'h12);
        do_op("lw", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd9, 1'b1, 0, -1);
        check("lw.const", vd, 32'h1234_5678);
        for (int i = 0; i < 4; i++)
            check($sformatf("lw.ram_a%0d", i), a_log[1 + i], 32'h1000 + 32'(i));

        // Byte/half sign and zero extension.
        preload(32'h2002, 8'hFF); preload(32'h2003, 8'h80);
        do_op("lb", 1'b1, 1'b0, 3'b000, 32'h2003, 32'h0, 5'd1, 1'b1, 0, -1);
        check("lb.const", vd, 32'hFFFF_FF80);
        do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h2003, 32'h0, 5'd2, 1'b1, 0, -1);
        check("lbu.const", vd, 32'h0000_0080);
        do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 5'd3, 1'b1, 0, -1);
        check("lhu.const", vd, 32'h0000_80FF);
        do_op("lh", 1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 5'd3, 1'b1, 0, -1);
        check("lh.const", vd, 32'hFFFF_80FF);

        // SH wrapping past the top of the address space.
        do_op("sh_wrap", 1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd0, 1'b0, 0, -1);
        check("sh_wrap.hi", 32'(ram_rd(32'hFFFF_FFFF)), 32'h0000_00DD);
        check("sh_wrap.lo", 32'(ram_rd(32'h0000_0000)), 32'h0000_00CC);

        // Grant withheld, rdy freeze mid-load, both flags set, no writeback.
        do_op("lw_grant", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd4, 1'b1, 4, -1);
        do_op("lw_pause", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd6, 1'b1, 0, 3);
        check("lw_pause.const", vd, 32'h1234_5678);
        do_op("rw_both", 1'b1, 1'b1, 3'b010, 32'h1001, 32'h5555_5555, 5'd8, 1'b1, 0, -1);
        do_op("ld_norden", 1'b1, 1'b0, 3'b100, 32'h1002, 32'h0, 5'd10, 1'b0, 0, -1);

        // SW aborted by reset after two bytes have gone out.
        bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b1; bus.in_mem_op = 3'b010;
        bus.in_vd = 32'h3000; bus.in_store_data = 32'h1122_3344; bus.mem_grant = 1'b1;
        bus.in_rd = 5'd0; bus.in_rd_enable = 1'b0;
        ref_mem[32'h3000] = 8'h44; ref_mem[32'h3001] = 8'h33;
        repeat (3) @(negedge clk);
        rst = 1'b1; #1;
        check("sw_rst.out_vd", bus.out_vd, 32'd0);
        check("sw_rst.stall", 32'(bus.stall_req), 32'd0);
        check("sw_rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("sw_rst.ram_wr", 32'(bus.ram_wr), 32'd0);
        check("sw_rst.ram_a", bus.ram_a, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.in_mem_write = 1'b0; bus.mem_grant = 1'b0;
        bus.in_vd = 32'h55; bus.in_rd = 5'd3; bus.in_rd_enable = 1'b1; #1;
        check("sw_rst.idle_stall", 32'(bus.stall_req), 32'd0);
        check("sw_rst.idle_vd", bus.out_vd, 32'h55);
        for (int i = 0; i < 4; i++)
            check($sformatf("sw_rst.mem%0d", i), 32'(ram_rd(32'h3000 + 32'(i))), 32'(ref_rd(32'h3000 + 32'(i))));
        @(negedge clk);

        // Random loads and stores against the memory model.
        for (int t = 0; t < 24; t++) begin
            ld    = 1'($urandom_range(0, 1));
            op    = ld ? ld_ops[$urandom_range(0, 4)] : st_ops[$urandom_range(0, 2)];
            wr_f  = ld ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            sdata = $urandom;
            rd    = 5'($urandom_range(1, 31));
            rd_en = ld ? 1'($urandom_range(0, 4) != 0) : 1'b0;
            gd    = int'($urandom_range(0, 2));
            pause_at = ($urandom_range(0, 2) == 0) ? gd + 1 + int'($urandom_range(0, n_bytes(op) - 1)) : -1;
            do_op($sformatf("rnd%0d", t), ld, wr_f, op, addr, sdata, rd, rd_en, gd, pause_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
